// File: rtl/mos6502_pkg.sv
// Shared encodings for the 6502 addressing-mode sequencer: mode codes, sequencer
// states, default zero-page location and operand-byte counts.
package mos6502_pkg;

  localparam logic [3:0] MODE_IMM   = 4'd0;
  localparam logic [3:0] MODE_ZP    = 4'd1;
  localparam logic [3:0] MODE_ZPX   = 4'd2;
  localparam logic [3:0] MODE_ZPY   = 4'd3;
  localparam logic [3:0] MODE_ABS   = 4'd4;
  localparam logic [3:0] MODE_ABSX  = 4'd5;
  localparam logic [3:0] MODE_ABSY  = 4'd6;
  localparam logic [3:0] MODE_INDX  = 4'd7;
  localparam logic [3:0] MODE_INDY  = 4'd8;
  localparam logic [3:0] MODE_ZPIND = 4'd9;
  localparam logic [3:0] MODE_IMPL  = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP0,
    ST_OP1,
    ST_IDX,
    ST_PTRL,
    ST_PTRH,
    ST_FIX,
    ST_DONE
  } seq_state_e;

  localparam logic [7:0] ZP_PAGE_DEFAULT = 8'h00;

  localparam logic [1:0] PC_ADV_NONE = 2'd0;
  localparam logic [1:0] PC_ADV_ONE  = 2'd1;
  localparam logic [1:0] PC_ADV_TWO  = 2'd2;

  // Operand bytes consumed; expects a mode already folded (unknown codes -> IMPL).
  function automatic logic [1:0] pc_adv_of(input logic [3:0] m);
    case (m)
      MODE_IMM, MODE_ZP, MODE_ZPX, MODE_ZPY,
      MODE_INDX, MODE_INDY, MODE_ZPIND:      pc_adv_of = PC_ADV_ONE;
      MODE_ABS, MODE_ABSX, MODE_ABSY:        pc_adv_of = PC_ADV_TWO;
      default:                               pc_adv_of = PC_ADV_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mos_page_adder.sv
// 8-bit base + index adder producing the in-page sum and the page-crossing carry.
module mos_page_adder (
  input  logic [7:0] base_i,
  input  logic [7:0] index_i,
  output logic [7:0] sum_o,
  output logic       carry_o
);

  assign {carry_o, sum_o} = {1'b0, base_i} + {1'b0, index_i};

endmodule

// File: rtl/mos_addr_seq.sv
// 6502 addressing-mode sequencer: walks operand/pointer/index/page-fix cycles and
// emits the effective address. Define MOS_AGU_ZPIND_EN to enable the 65C02 (zp) mode.
module mos_addr_seq
  import mos6502_pkg::*;
#(
  parameter logic [7:0] ZP_PAGE   = ZP_PAGE_DEFAULT,
  parameter bit         STORE_FIX = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [3:0]  mode_i,
  input  logic [7:0]  index_i,
  input  logic        is_store_i,
  input  logic [15:0] pc_in_i,
  input  logic [7:0]  di_i,
  input  logic        rdy_i,
  output logic [15:0] ab_o,
  output logic        dummy_o,
  output logic        busy_o,
  output logic [15:0] ea_o,
  output logic        ea_valid_o,
  output logic [1:0]  pc_adv_o
);

`ifdef MOS_AGU_ZPIND_EN
  localparam bit ZPIND_EN = 1'b1;
`else
  localparam bit ZPIND_EN = 1'b0;
`endif

  seq_state_e  state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [7:0]  idx_q, idx_d;
  logic        store_q, store_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  ptrl_q, ptrl_d;

  logic [3:0]  mode_eff;
  logic [7:0]  add_base;
  logic [7:0]  add_sum;
  logic        add_carry;
  logic        need_fix;

  // Unsupported codes collapse to IMPL at capture so later states see only legal modes.
  assign mode_eff = ((mode_i > MODE_IMPL) || ((mode_i == MODE_ZPIND) && !ZPIND_EN))
                    ? MODE_IMPL : mode_i;

  // In PTRH the low pointer byte is still in ptrl_q; everywhere else the base is lo_q.
  assign add_base = (state_q == ST_PTRH) ? ptrl_q : lo_q;
  assign need_fix = add_carry | (store_q & STORE_FIX);
  assign busy_o   = (state_q != ST_IDLE);

  mos_page_adder u_page_adder (
    .base_i  (add_base),
    .index_i (idx_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    store_d    = store_q;
    pc_d       = pc_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    ptrl_d     = ptrl_q;
    ab_o       = 16'h0000;
    dummy_o    = 1'b0;
    ea_o       = 16'h0000;
    ea_valid_o = 1'b0;
    pc_adv_o   = PC_ADV_NONE;

    case (state_q)
      ST_IDLE: begin
        ab_o = pc_in_i;
        if (start_i) begin
          mode_d  = mode_eff;
          idx_d   = index_i;
          store_d = is_store_i;
          pc_d    = pc_in_i;
          state_d = ((mode_eff == MODE_IMM) || (mode_eff == MODE_IMPL)) ? ST_DONE : ST_OP0;
        end
      end
      ST_OP0: begin
        ab_o = pc_q;
        if (rdy_i) begin
          lo_d = di_i;
          case (mode_q)
            MODE_ZP:                         state_d = ST_DONE;
            MODE_ZPX, MODE_ZPY, MODE_INDX:   state_d = ST_IDX;
            MODE_ABS, MODE_ABSX, MODE_ABSY:  state_d = ST_OP1;
            default:                         state_d = ST_PTRL;
          endcase
        end
      end
      ST_OP1: begin
        ab_o = pc_q + 16'd1;
        if (rdy_i) begin
          hi_d    = di_i;
          state_d = ((mode_q != MODE_ABS) && need_fix) ? ST_FIX : ST_DONE;
        end
      end
      ST_IDX: begin
        ab_o    = {ZP_PAGE, lo_q};
        dummy_o = 1'b1;
        if (rdy_i) begin
          lo_d    = add_sum;
          state_d = (mode_q == MODE_INDX) ? ST_PTRL : ST_DONE;
        end
      end
      ST_PTRL: begin
        ab_o = {ZP_PAGE, lo_q};
        if (rdy_i) begin
          ptrl_d  = di_i;
          state_d = ST_PTRH;
        end
      end
      ST_PTRH: begin
        ab_o = {ZP_PAGE, lo_q + 8'd1};
        if (rdy_i) begin
          hi_d    = di_i;
          lo_d    = ptrl_q;
          state_d = ((mode_q == MODE_INDY) && need_fix) ? ST_FIX : ST_DONE;
        end
      end
      ST_FIX: begin
        ab_o    = {hi_q, add_sum};
        dummy_o = 1'b1;
        if (rdy_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ea_valid_o = 1'b1;
        pc_adv_o   = pc_adv_of(mode_q);
        case (mode_q)
          MODE_IMM:                         ea_o = pc_q;
          MODE_ZP, MODE_ZPX, MODE_ZPY:      ea_o = {ZP_PAGE, lo_q};
          MODE_ABS, MODE_INDX, MODE_ZPIND:  ea_o = {hi_q, lo_q};
          MODE_ABSX, MODE_ABSY, MODE_INDY:  ea_o = {hi_q + {7'b0, add_carry}, add_sum};
          default:                          ea_o = 16'h0000;
        endcase
        ab_o    = ea_o;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_IMM;
      idx_q   <= 8'h00;
      store_q <= 1'b0;
      pc_q    <= 16'h0000;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      ptrl_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ptrl_q  <= ptrl_d;
    end
  end

endmodule

// File: tb/tb_mos_addr_seq.sv
// Scoreboard bench for mos_addr_seq: directed transactions push expected EA/pc_adv,
// a negedge monitor pops and compares on every ea_valid pulse.
module tb_mos_addr_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [7:0]  index = 8'h00;
  logic        is_store = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  di;
  logic        rdy = 1'b1;
  logic [15:0] ab;
  logic        dummy;
  logic        busy;
  logic [15:0] ea;
  logic        ea_valid;
  logic [1:0]  pc_adv;

  logic [7:0]  mem [0:65535];

  typedef struct {
    string       name;
    logic [15:0] ea;
    logic [1:0]  adv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  mos_addr_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .mode_i     (mode),
    .index_i    (index),
    .is_store_i (is_store),
    .pc_in_i    (pc_in),
    .di_i       (di),
    .rdy_i      (rdy),
    .ab_o       (ab),
    .dummy_o    (dummy),
    .busy_o     (busy),
    .ea_o       (ea),
    .ea_valid_o (ea_valid),
    .pc_adv_o   (pc_adv)
  );

  always #5 clk = ~clk;
  assign di = mem[ab];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: every ea_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && ea_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ea_valid: got ea=%h with no transaction outstanding", ea);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_ea"}, {16'h0, ea}, {16'h0, e.ea});
        chk({e.name, "_pc_adv"}, {30'h0, pc_adv}, {30'h0, e.adv});
        $display("txn %s: ea=%h pc_adv=%0d", e.name, ea, pc_adv);
      end
    end
  end

  // One transaction. lat counts clock edges from the edge capturing start to DONE.
  // c1/c2 select cycles whose bus address/dummy flag are checked; stall_at/stall_n drop
  // rdy in a given cycle; reset_at asserts reset in a given cycle (no ea expected).
  task automatic run(input string name, input logic [3:0] m, input logic [7:0] ix,
                     input logic st, input logic [15:0] pc,
                     input logic [15:0] e_ea, input logic [1:0] e_adv, input int e_lat,
                     input int c1, input logic [15:0] ab1, input logic d1,
                     input int c2, input logic [15:0] ab2, input logic d2,
                     input int stall_at, input int stall_n, input logic [15:0] stall_ab,
                     input int reset_at);
    int  lat;
    bit  done;
    exp_t e;
    @(negedge clk);
    mode = m; index = ix; is_store = st; pc_in = pc; start = 1'b1;
    if (reset_at == 0) begin
      e.name = name; e.ea = e_ea; e.adv = e_adv;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    done = 1'b0;
    for (int guard = 0; guard < 30 && !done; guard++) begin
      @(negedge clk);
      if (lat == c1) begin
        chk({name, "_ab1"}, {16'h0, ab}, {16'h0, ab1});
        chk({name, "_dummy1"}, {31'h0, dummy}, {31'h0, d1});
      end
      if (lat == c2) begin
        chk({name, "_ab2"}, {16'h0, ab}, {16'h0, ab2});
        chk({name, "_dummy2"}, {31'h0, dummy}, {31'h0, d2});
      end
      if (lat == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_busy_after_reset"}, {31'h0, busy}, 32'h0);
        chk({name, "_ea_valid_after_reset"}, {31'h0, ea_valid}, 32'h0);
        reset = 1'b0;
        $display("txn %s: reset mid-sequence, busy=%0d", name, busy);
        return;
      end
      if (lat == stall_at) begin
        rdy = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          chk({name, "_stall_ab"}, {16'h0, ab}, {16'h0, stall_ab});
          chk({name, "_stall_no_valid"}, {31'h0, ea_valid}, 32'h0);
        end
        rdy = 1'b1;
      end
      if (ea_valid) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no ea_valid within bound, required latency %0d", name, e_lat);
    end else begin
      chk({name, "_latency"}, lat, e_lat);
    end
  endtask

  logic [15:0] zpind_ea;
  logic [1:0]  zpind_adv;
  int          zpind_lat;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0400] = 8'h42;
    mem[16'h0410] = 8'hF0;
    mem[16'h0500] = 8'h34; mem[16'h0501] = 8'h12;
    mem[16'h0510] = 8'hFF; mem[16'h0511] = 8'h12;
    mem[16'h0520] = 8'h10; mem[16'h0521] = 8'h20;
    mem[16'h0530] = 8'hFE; mem[16'h00FF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h0540] = 8'h80; mem[16'h0080] = 8'hF0; mem[16'h0081] = 8'h33;
    mem[16'h0550] = 8'h78; mem[16'h0551] = 8'h56;
    mem[16'h0560] = 8'h90; mem[16'h0090] = 8'hEF; mem[16'h0091] = 8'hBE;
    mem[16'h0570] = 8'hFF; mem[16'h0571] = 8'hFF;

`ifdef MOS_AGU_ZPIND_EN
    zpind_ea = 16'hBEEF; zpind_adv = 2'd1; zpind_lat = 4;
`else
    zpind_ea = 16'h0000; zpind_adv = 2'd0; zpind_lat = 1;
`endif

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_ea_valid", {31'h0, ea_valid}, 32'h0);
    chk("reset_dummy", {31'h0, dummy}, 32'h0);
    chk("reset_ea", {16'h0, ea}, 32'h0);
    chk("reset_pc_adv", {30'h0, pc_adv}, 32'h0);
    chk("reset_ab", {16'h0, ab}, 32'h0);
    reset = 1'b0;

    //   name       mode   idx    st    pc        ea        adv  lat  c1 ab1      d1    c2 ab2      d2    stall          reset
    run("imm",      4'd0,  8'h00, 1'b0, 16'h0300, 16'h0300, 2'd1, 1, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("impl",     4'd10, 8'h00, 1'b0, 16'h0310, 16'h0000, 2'd0, 1, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("mode13",   4'd13, 8'h00, 1'b0, 16'h0320, 16'h0000, 2'd0, 1, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("zp",       4'd1,  8'h00, 1'b0, 16'h0400, 16'h0042, 2'd1, 2, 1, 16'h0400, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("zpx_wrap", 4'd2,  8'h20, 1'b0, 16'h0410, 16'h0010, 2'd1, 3, 1, 16'h0410, 1'b0, 2, 16'h00F0, 1'b1, 0, 0, 16'h0, 0);
    run("abs",      4'd4,  8'h00, 1'b0, 16'h0500, 16'h1234, 2'd2, 3, 1, 16'h0500, 1'b0, 2, 16'h0501, 1'b0, 0, 0, 16'h0, 0);
    run("absx_fix", 4'd5,  8'h01, 1'b0, 16'h0510, 16'h1300, 2'd2, 4, 2, 16'h0511, 1'b0, 3, 16'h1200, 1'b1, 0, 0, 16'h0, 0);
    run("absx_nofix",4'd5, 8'h00, 1'b0, 16'h0510, 16'h12FF, 2'd2, 3, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("absy_store",4'd6, 8'h05, 1'b1, 16'h0520, 16'h2015, 2'd2, 4, 0, 16'h0, 1'b0, 3, 16'h2015, 1'b1, 0, 0, 16'h0, 0);
    run("indx_wrap",4'd7,  8'h01, 1'b0, 16'h0530, 16'hABCD, 2'd1, 5, 3, 16'h00FF, 1'b0, 4, 16'h0000, 1'b0, 0, 0, 16'h0, 0);
    run("indy_fix", 4'd8,  8'h20, 1'b0, 16'h0540, 16'h3410, 2'd1, 5, 2, 16'h0080, 1'b0, 4, 16'h3310, 1'b1, 0, 0, 16'h0, 0);
    run("abs_stall",4'd4,  8'h00, 1'b0, 16'h0550, 16'h5678, 2'd2, 6, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 2, 3, 16'h0551, 0);
    run("absx_ea_wrap",4'd5,8'h01,1'b0, 16'h0570, 16'h0000, 2'd2, 4, 0, 16'h0, 1'b0, 3, 16'hFF00, 1'b1, 0, 0, 16'h0, 0);
    run("indx_reset",4'd7, 8'h01, 1'b0, 16'h0530, 16'h0000, 2'd0, 0, 4, 16'h0000, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 4);
    run("zp_after_reset",4'd1,8'h00,1'b0,16'h0400, 16'h0042, 2'd1, 2, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);
    run("zpind",    4'd9,  8'h07, 1'b0, 16'h0560, zpind_ea, zpind_adv, zpind_lat, 0, 16'h0, 1'b0, 0, 16'h0, 1'b0, 0, 0, 16'h0, 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
